// File: rtl/ext_mem_model_if.sv
// Request/response bundle between the accelerator and the external memory model.
interface ext_mem_model_if #(
    parameter int unsigned AW  = 26,
    parameter int unsigned DW  = 32,
    parameter int unsigned IAW = 13
);
    // write request port
    logic           wvalid;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           wready;

    // read request port
    logic           rvalid;
    logic [AW-1:0]  raddr;
    logic           rready;
    logic [DW-1:0]  rdata;

    // instruction fetch port
    logic [IAW-1:0] iaddr;
    logic [DW-1:0]  idata;

    modport master (
        output wvalid, waddr, wdata, rvalid, raddr, iaddr,
        input  wready, rready, rdata, idata
    );

    modport slave (
        input  wvalid, waddr, wdata, rvalid, raddr, iaddr,
        output wready, rready, rdata, idata
    );
endinterface

// File: rtl/ext_mem_model.sv
// Behavioural external memory: data SRAM with independent fixed-latency
// read and write ports, plus a registered instruction ROM.
module ext_mem_model #(
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned WR_LATENCY = 4,
    parameter int unsigned AW         = 26,
    parameter int unsigned DW         = 32,
    parameter int unsigned IAW        = 13
) (
    input  logic            clk,
    input  logic            rst,
    ext_mem_model_if.slave  bus
);

    localparam int unsigned RAM_DEPTH = 2 ** AW;
    localparam int unsigned ROM_DEPTH = 2 ** IAW;
    localparam int unsigned RCW       = $clog2(RD_LATENCY + 1);
    localparam int unsigned WCW       = $clog2(WR_LATENCY + 1);

    // counter reload values: ready fires when the counter has run down to zero
    localparam logic [RCW-1:0] RD_INIT = RCW'(RD_LATENCY - 1);
    localparam logic [WCW-1:0] WR_INIT = WCW'(WR_LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } port_state_t;

    logic [DW-1:0] ram [RAM_DEPTH];
    logic [DW-1:0] rom [ROM_DEPTH];

    // write port
    port_state_t   wr_state;
    port_state_t   wr_state_nxt;
    logic [WCW-1:0] wr_cnt;
    logic [WCW-1:0] wr_cnt_nxt;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          wr_ready_q;
    logic          wr_ready_nxt;
    logic          wr_cap;

    // read port
    port_state_t   rd_state;
    port_state_t   rd_state_nxt;
    logic [RCW-1:0] rd_cnt;
    logic [RCW-1:0] rd_cnt_nxt;
    logic [AW-1:0] rd_addr_q;
    logic          rd_ready_q;
    logic          rd_ready_nxt;
    logic          rd_cap;
    logic [AW-1:0] rd_load_addr;
    logic          rd_fwd;
    logic [DW-1:0] rdata_q;

    // instruction port
    logic [DW-1:0] idata_q;

    // Backdoor preload of instruction contents; the ROM has no functional write path.
    task automatic load_rom(input logic [IAW-1:0] addr, input logic [DW-1:0] data);
        rom[addr] = data;
    endtask

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------

    // Write port state, counter, request capture and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state   <= IDLE;
            wr_cnt     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            wr_state   <= wr_state_nxt;
            wr_cnt     <= wr_cnt_nxt;
            wr_ready_q <= wr_ready_nxt;
            if (wr_cap) begin
                wr_addr_q <= bus.waddr;
                wr_data_q <= bus.wdata;
            end
        end
    end

    // Write port next state: accept in IDLE, count down in BUSY.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_cnt_nxt   = wr_cnt;
        case (wr_state)
            IDLE: begin
                if (bus.wvalid) begin
                    wr_state_nxt = BUSY;
                    wr_cnt_nxt   = WR_INIT;
                end
            end
            BUSY: begin
                if (wr_cnt == '0) begin
                    wr_state_nxt = IDLE;
                end else begin
                    wr_cnt_nxt = wr_cnt - WCW'(1);
                end
            end
            default: begin
                wr_state_nxt = IDLE;
            end
        endcase
    end

    // Write port outputs: capture strobe and the ready value for next cycle.
    always_comb begin
        wr_cap       = 1'b0;
        wr_ready_nxt = 1'b0;
        case (wr_state)
            IDLE: begin
                wr_cap       = bus.wvalid;
                wr_ready_nxt = bus.wvalid && (WR_INIT == '0);
            end
            BUSY: begin
                wr_ready_nxt = (wr_cnt == WCW'(1));
            end
            default: begin
                wr_ready_nxt = 1'b0;
            end
        endcase
    end

    // Commit the captured write on the edge that closes the ready cycle.
    always_ff @(posedge clk) begin
        if (wr_ready_q) begin
            ram[wr_addr_q] <= wr_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------

    // Read port state, counter, address capture and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state   <= IDLE;
            rd_cnt     <= '0;
            rd_addr_q  <= '0;
            rd_ready_q <= 1'b0;
        end else begin
            rd_state   <= rd_state_nxt;
            rd_cnt     <= rd_cnt_nxt;
            rd_ready_q <= rd_ready_nxt;
            if (rd_cap) begin
                rd_addr_q <= bus.raddr;
            end
        end
    end

    // Read port next state: accept in IDLE, count down in BUSY.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_cnt_nxt   = rd_cnt;
        case (rd_state)
            IDLE: begin
                if (bus.rvalid) begin
                    rd_state_nxt = BUSY;
                    rd_cnt_nxt   = RD_INIT;
                end
            end
            BUSY: begin
                if (rd_cnt == '0) begin
                    rd_state_nxt = IDLE;
                end else begin
                    rd_cnt_nxt = rd_cnt - RCW'(1);
                end
            end
            default: begin
                rd_state_nxt = IDLE;
            end
        endcase
    end

    // Read port outputs; with latency 1 the data is fetched from the live request address.
    always_comb begin
        rd_cap       = 1'b0;
        rd_ready_nxt = 1'b0;
        rd_load_addr = rd_addr_q;
        case (rd_state)
            IDLE: begin
                rd_cap       = bus.rvalid;
                rd_ready_nxt = bus.rvalid && (RD_INIT == '0);
                rd_load_addr = bus.raddr;
            end
            BUSY: begin
                rd_ready_nxt = (rd_cnt == RCW'(1));
            end
            default: begin
                rd_ready_nxt = 1'b0;
            end
        endcase
    end

    // A write committing on the same edge the read data is loaded must be seen by that read.
    assign rd_fwd = wr_ready_q && (wr_addr_q == rd_load_addr);

    // Load read data entering the ready cycle; hold it until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_ready_nxt) begin
            rdata_q <= rd_fwd ? wr_data_q : ram[rd_load_addr];
        end
    end

    // ------------------------------------------------------------------
    // Instruction ROM
    // ------------------------------------------------------------------

    // Registered instruction fetch, one cycle from address to data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idata_q <= '0;
        end else begin
            idata_q <= rom[bus.iaddr];
        end
    end

    assign bus.wready = wr_ready_q;
    assign bus.rready = rd_ready_q;
    assign bus.rdata  = rdata_q;
    assign bus.idata  = idata_q;

endmodule

// File: tb/tb_ext_mem_model.sv
// Scoreboard bench for ext_mem_model at default parameters.
`timescale 1ns/1ps
module tb_ext_mem_model;

    localparam int unsigned RDL = 3;
    localparam int unsigned WRL = 4;

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] data;
    } rd_exp_t;

    logic clk;
    logic rst;
    int unsigned cyc;
    int checks;
    int errors;

    rd_exp_t     rd_q[$];
    int unsigned wr_q[$];

    ext_mem_model_if #(.AW(26), .DW(32), .IAW(13)) bus ();

    ext_mem_model #(
        .RD_LATENCY(RDL),
        .WR_LATENCY(WRL),
        .AW(26),
        .DW(32),
        .IAW(13)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle index of the current clock period
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pop expectations when the DUT signals completion.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
            e = rd_q.pop_front();
            check("rready_on_time", 64'(bus.rready), 64'(1));
            if (bus.rready) check("rdata", 64'(bus.rdata), 64'(e.data));
        end else if (bus.rready) begin
            check("rready_unexpected", 64'(bus.rready), 64'(0));
        end
        if (wr_q.size() != 0 && wr_q[0] == cyc) begin
            void'(wr_q.pop_front());
            check("wready_on_time", 64'(bus.wready), 64'(1));
        end else if (bus.wready) begin
            check("wready_unexpected", 64'(bus.wready), 64'(0));
        end
    end

    task automatic wr_req(input logic [25:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.wvalid = 1'b1;
        bus.waddr  = addr;
        bus.wdata  = data;
        wr_q.push_back(cyc + WRL);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        repeat (WRL) @(posedge clk);
    endtask

    task automatic rd_req(input logic [25:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        bus.rvalid = 1'b1;
        bus.raddr  = addr;
        rd_q.push_back('{cyc + RDL, exp});
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        repeat (RDL) @(posedge clk);
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst        = 1'b1;
        bus.wvalid = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.rvalid = 1'b0;
        bus.raddr  = '0;
        bus.iaddr  = '0;

        repeat (3) @(posedge clk); #1;
        check("reset_wready", 64'(bus.wready), 64'(0));
        check("reset_rready", 64'(bus.rready), 64'(0));
        check("reset_rdata",  64'(bus.rdata),  64'(0));
        check("reset_idata",  64'(bus.idata),  64'(0));
        rst = 1'b0;

        dut.load_rom(13'd5,      32'hCAFEF00D);
        dut.load_rom(13'h1FFF,   32'h5A5A1234);

        // preload then basic read at latency 3
        wr_req(26'h10, 32'hDEADBEEF);
        rd_req(26'h10, 32'hDEADBEEF);

        // top of address space
        wr_req(26'h3FFFFFF, 32'h12345678);
        rd_req(26'h3FFFFFF, 32'h12345678);

        // same-cycle collision returns old data, later read sees new data
        wr_req(26'h20, 32'h0000000A);
        @(posedge clk); #1;
        bus.wvalid = 1'b1;
        bus.waddr  = 26'h20;
        bus.wdata  = 32'h0000000B;
        wr_q.push_back(cyc + WRL);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        bus.rvalid = 1'b1;
        bus.raddr  = 26'h20;
        rd_q.push_back('{cyc + RDL, 32'h0000000A});
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        repeat (5) @(posedge clk);
        rd_req(26'h20, 32'h0000000B);

        // write done in cycle N is visible to a read ready in N+1
        wr_req(26'h30, 32'h00000044);
        @(posedge clk); #1;
        bus.wvalid = 1'b1;
        bus.waddr  = 26'h30;
        bus.wdata  = 32'h00000055;
        wr_q.push_back(cyc + WRL);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        @(posedge clk); #1;
        bus.rvalid = 1'b1;
        bus.raddr  = 26'h30;
        rd_q.push_back('{cyc + RDL, 32'h00000055});
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        repeat (5) @(posedge clk);

        // rvalid held 10 cycles, raddr wiggled while busy
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                bus.rvalid = 1'b1;
                rd_q.push_back('{cyc + 3,  32'hDEADBEEF});
                rd_q.push_back('{cyc + 7,  32'h12345678});
                rd_q.push_back('{cyc + 11, 32'h0000000B});
            end
            if (k == 0)      bus.raddr = 26'h10;
            else if (k == 4) bus.raddr = 26'h3FFFFFF;
            else             bus.raddr = 26'h20;
        end
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        repeat (4) @(posedge clk);

        // instruction ROM, one-cycle latency
        @(posedge clk); #1;
        bus.iaddr = 13'd5;
        @(posedge clk); #1;
        check("rom_5", 64'(bus.idata), 64'(32'hCAFEF00D));
        bus.iaddr = 13'h1FFF;
        @(posedge clk); #1;
        check("rom_top", 64'(bus.idata), 64'(32'h5A5A1234));

        // asynchronous reset in cycle 2 of a pending write
        @(posedge clk); #1;
        bus.wvalid = 1'b1;
        bus.waddr  = 26'h10;
        bus.wdata  = 32'h11111111;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_wready", 64'(bus.wready), 64'(0));
        check("arst_rready", 64'(bus.rready), 64'(0));
        check("arst_rdata",  64'(bus.rdata),  64'(0));
        check("arst_idata",  64'(bus.idata),  64'(0));
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        rd_req(26'h10, 32'hDEADBEEF);

        repeat (5) @(posedge clk); #1;
        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check("wr_q_drained", 64'(wr_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
